// File: rtl/fpnew_pkg.sv
// rtl/fpnew_pkg.sv - shared FPU types used by the result buffer
//
// Holds the subset of the fpnew package that the result buffer depends on:
//   status_t    : IEEE exception flags {NV, DZ, OF, UF, NX}, NX in bit 0
//   classmask_e : one-hot classify result, QNAN is the idle/reset class
package fpnew_pkg;

  typedef struct packed {
    logic NV;  // invalid
    logic DZ;  // divide by zero
    logic OF;  // overflow
    logic UF;  // underflow
    logic NX;  // inexact
  } status_t;

  typedef enum logic [9:0] {
    NEGINF     = 10'b00_0000_0001,
    NEGNORM    = 10'b00_0000_0010,
    NEGSUBNORM = 10'b00_0000_0100,
    NEGZERO    = 10'b00_0000_1000,
    POSZERO    = 10'b00_0001_0000,
    POSSUBNORM = 10'b00_0010_0000,
    POSNORM    = 10'b00_0100_0000,
    POSINF     = 10'b00_1000_0000,
    SNAN       = 10'b01_0000_0000,
    QNAN       = 10'b10_0000_0000
  } classmask_e;

endpackage

// File: rtl/fpnew_result_buffer.sv
// rtl/fpnew_result_buffer.sv - elastic in-order result buffer with sticky exception flags
//
// Purpose: decouples an FPU operation group's output pipeline from the result
// arbiter. Stores up to Depth beats (result/status/class/tag/aux) and collects
// the sticky OR of the status of every beat delivered downstream.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   result_i .. aux_i            incoming beat payload
//   in_valid_i / in_ready_o      upstream handshake (in_ready_o independent of out_ready_i)
//   flush_i                      drop all stored beats and the incoming beat
//   result_o .. aux_o            head-of-buffer payload
//   out_valid_o / out_ready_i    downstream handshake
//   fflags_o / fflags_clr_i      sticky exception flags and their clear
//   count_o, busy_o              occupancy and non-empty indication
//
// Optional feature: FPNEW_RESULT_BUFFER_BYPASS_EN lets a beat arriving at an
// empty buffer appear on the outputs in the same cycle.
module fpnew_result_buffer #(
  parameter int unsigned Width   = 32,
  parameter int unsigned Depth   = 2,
  parameter type         TagType = logic,
  parameter type         AuxType = logic,
  localparam int unsigned CntW   = $clog2(Depth + 1),
  localparam int unsigned PtrW   = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [Width-1:0]       result_i,
  input  fpnew_pkg::status_t     status_i,
  input  logic                   extension_bit_i,
  input  fpnew_pkg::classmask_e  class_mask_i,
  input  logic                   is_class_i,
  input  TagType                 tag_i,
  input  AuxType                 aux_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic                   flush_i,
  output logic [Width-1:0]       result_o,
  output fpnew_pkg::status_t     status_o,
  output logic                   extension_bit_o,
  output fpnew_pkg::classmask_e  class_mask_o,
  output logic                   is_class_o,
  output TagType                 tag_o,
  output AuxType                 aux_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output fpnew_pkg::status_t     fflags_o,
  input  logic                   fflags_clr_i,
  output logic [CntW-1:0]        count_o,
  output logic                   busy_o
);
  import fpnew_pkg::*;

  typedef struct packed {
    logic [Width-1:0] result;
    status_t          status;
    logic             extension_bit;
    classmask_e       class_mask;
    logic             is_class;
    TagType           tag;
    AuxType           aux;
  } entry_t;

  entry_t          mem_q [Depth];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  status_t         fflags_q, fflags_d;

  entry_t in_entry, head, reset_entry;
  logic   empty, full, fire, push, pop;

  always_comb begin
    in_entry               = '0;
    in_entry.result        = result_i;
    in_entry.status        = status_i;
    in_entry.extension_bit = extension_bit_i;
    in_entry.class_mask    = class_mask_i;
    in_entry.is_class      = is_class_i;
    in_entry.tag           = tag_i;
    in_entry.aux           = aux_i;
    reset_entry            = '0;
    reset_entry.class_mask = QNAN;
  end

  assign empty      = (count_q == '0);
  assign full       = (count_q == CntW'(Depth));
  assign in_ready_o = ~full | flush_i;

`ifdef FPNEW_RESULT_BUFFER_BYPASS_EN
  // Empty buffer: the input beat is shown directly. When it is accepted
  // downstream in the same cycle it is consumed without being stored.
  assign out_valid_o = (~empty | in_valid_i) & ~flush_i;
  assign head        = empty ? in_entry : mem_q[rptr_q];
  assign fire        = out_valid_o & out_ready_i;
  assign pop         = fire & ~empty;
  assign push        = in_valid_i & in_ready_o & ~flush_i & ~(fire & empty);
`else
  assign out_valid_o = ~empty & ~flush_i;
  assign head        = mem_q[rptr_q];
  assign fire        = out_valid_o & out_ready_i;
  assign pop         = fire;
  assign push        = in_valid_i & in_ready_o & ~flush_i;
`endif

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + 1'b1;
      if (pop)  rptr_d = (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    // A clear in the same cycle as a delivery keeps the delivered flags.
    fflags_d = status_t'((fflags_clr_i ? 5'b0 : fflags_q) | (fire ? head.status : 5'b0));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      fflags_q <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      fflags_q <= fflags_d;
    end
  end

  // Payload storage only loads on push so it can be clock-gated.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= reset_entry;
    end else if (push) begin
      mem_q[wptr_q] <= in_entry;
    end
  end

  assign result_o        = head.result;
  assign status_o        = head.status;
  assign extension_bit_o = head.extension_bit;
  assign class_mask_o    = head.class_mask;
  assign is_class_o      = head.is_class;
  assign tag_o           = head.tag;
  assign aux_o           = head.aux;
  assign fflags_o        = fflags_q;
  assign count_o         = count_q;
  assign busy_o          = ~empty;

endmodule

// File: tb/tb_fpnew_result_buffer.sv
// tb/tb_fpnew_result_buffer.sv - directed self-checking bench for fpnew_result_buffer
module tb_fpnew_result_buffer;
  import fpnew_pkg::*;

  typedef logic [3:0] tag_t;
  typedef logic [1:0] aux_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] result_i = '0;
  status_t     status_i = '0;
  logic        ext_i = 1'b0;
  classmask_e  cls_i = POSNORM;
  logic        is_class_i = 1'b0;
  tag_t        tag_i = '0;
  aux_t        aux_i = '0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        clr = 1'b0;

  logic [31:0] d2_result, d4_result;
  status_t     d2_status, d4_status, d2_fflags, d4_fflags;
  logic        d2_ext, d4_ext, d2_isc, d4_isc;
  classmask_e  d2_cls, d4_cls;
  tag_t        d2_tag, d4_tag;
  aux_t        d2_aux, d4_aux;
  logic        d2_in_ready, d4_in_ready, d2_out_valid, d4_out_valid, d2_busy, d4_busy;
  logic [1:0]  d2_count;
  logic [2:0]  d4_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fpnew_result_buffer #(.Width(32), .Depth(2), .TagType(tag_t), .AuxType(aux_t)) u_d2 (
    .clk_i(clk), .rst_i(rst), .result_i(result_i), .status_i(status_i),
    .extension_bit_i(ext_i), .class_mask_i(cls_i), .is_class_i(is_class_i),
    .tag_i(tag_i), .aux_i(aux_i), .in_valid_i(in_valid), .in_ready_o(d2_in_ready),
    .flush_i(flush), .result_o(d2_result), .status_o(d2_status),
    .extension_bit_o(d2_ext), .class_mask_o(d2_cls), .is_class_o(d2_isc),
    .tag_o(d2_tag), .aux_o(d2_aux), .out_valid_o(d2_out_valid),
    .out_ready_i(out_ready), .fflags_o(d2_fflags), .fflags_clr_i(clr),
    .count_o(d2_count), .busy_o(d2_busy)
  );

  fpnew_result_buffer #(.Width(32), .Depth(4), .TagType(tag_t), .AuxType(aux_t)) u_d4 (
    .clk_i(clk), .rst_i(rst), .result_i(result_i), .status_i(status_i),
    .extension_bit_i(ext_i), .class_mask_i(cls_i), .is_class_i(is_class_i),
    .tag_i(tag_i), .aux_i(aux_i), .in_valid_i(in_valid), .in_ready_o(d4_in_ready),
    .flush_i(flush), .result_o(d4_result), .status_o(d4_status),
    .extension_bit_o(d4_ext), .class_mask_o(d4_cls), .is_class_o(d4_isc),
    .tag_o(d4_tag), .aux_o(d4_aux), .out_valid_o(d4_out_valid),
    .out_ready_i(out_ready), .fflags_o(d4_fflags), .fflags_clr_i(clr),
    .count_o(d4_count), .busy_o(d4_busy)
  );

  // Inputs change 1 time unit after the rising edge; checks sample 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0; out_ready = 0; flush = 0; clr = 0; status_i = '0;
    rst = 1; tick(); tick(); rst = 0; #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (d2_count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", d2_count); end
    checks++; if (d2_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", d2_out_valid); end
    checks++; if (d2_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", d2_in_ready); end
    checks++; if (d2_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", d2_busy); end
    checks++; if (d2_fflags !== 5'h00) begin errors++; $display("FAIL reset_fflags got %h exp 00", d2_fflags); end
    checks++; if (d2_result !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 0", d2_result); end
    checks++; if (d2_cls !== QNAN) begin errors++; $display("FAIL reset_class got %h exp %h", d2_cls, QNAN); end
  endtask

  task automatic test_single();
    do_reset();
    result_i = 32'h3F80_0000; tag_i = 4'd1; in_valid = 1; out_ready = 1; #1;
    checks++; if (d2_out_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass got %b exp 0", d2_out_valid); end
    tick(); in_valid = 0; #1;
    checks++; if (d2_out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", d2_out_valid); end
    checks++; if (d2_result !== 32'h3F80_0000) begin errors++; $display("FAIL single_result got %h exp 3f800000", d2_result); end
    checks++; if (d2_tag !== 4'd1) begin errors++; $display("FAIL single_tag got %0d exp 1", d2_tag); end
    tick();
    checks++; if (d2_count !== 2'd0) begin errors++; $display("FAIL single_count got %0d exp 0", d2_count); end
    checks++; if (d2_busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b exp 0", d2_busy); end
  endtask

  task automatic test_full();
    do_reset();
    in_valid = 1; result_i = 32'd1; tick();
    result_i = 32'd2; tick();
    result_i = 32'd3; #1;
    checks++; if (d2_in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", d2_in_ready); end
    checks++; if (d2_count !== 2'd2) begin errors++; $display("FAIL full_count got %0d exp 2", d2_count); end
    tick();
    checks++; if (d2_count !== 2'd2) begin errors++; $display("FAIL full_hold_count got %0d exp 2", d2_count); end
    out_ready = 1; #1;
    checks++; if (d2_result !== 32'd1) begin errors++; $display("FAIL order_beat1 got %0d exp 1", d2_result); end
    tick();
    checks++; if (d2_result !== 32'd2 || d2_count !== 2'd1) begin errors++; $display("FAIL order_beat2 got %0d/%0d exp 2/1", d2_result, d2_count); end
    checks++; if (d2_in_ready !== 1'b1) begin errors++; $display("FAIL refill_ready got %b exp 1", d2_in_ready); end
    tick(); in_valid = 0; #1;
    checks++; if (d2_result !== 32'd3 || d2_count !== 2'd1) begin errors++; $display("FAIL order_beat3 got %0d/%0d exp 3/1", d2_result, d2_count); end
    tick(); out_ready = 0;
    checks++; if (d2_count !== 2'd0) begin errors++; $display("FAIL drain_count got %0d exp 0", d2_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; result_i = 32'd100 + 32'(i); tag_i = 4'(i);
      tick();
      checks++;
      if (d4_out_valid !== 1'b1 || d4_result !== 32'd100 + 32'(i) || d4_count !== 3'd1 || d4_tag !== 4'(i))
        begin errors++; $display("FAIL b2b_beat%0d got v=%b r=%0d c=%0d exp v=1 r=%0d c=1", i, d4_out_valid, d4_result, d4_count, 100 + i); end
    end
    in_valid = 0; tick(); out_ready = 0;
    checks++; if (d4_count !== 3'd0) begin errors++; $display("FAIL b2b_drain got %0d exp 0", d4_count); end
  endtask

  task automatic test_fflags();
    do_reset();
    in_valid = 1; status_i = 5'h01; tick();
    status_i = 5'h10; tick();
    in_valid = 0; #1;
    checks++; if (d2_fflags !== 5'h00) begin errors++; $display("FAIL flags_undelivered got %h exp 00", d2_fflags); end
    out_ready = 1; tick(); tick(); out_ready = 0; #1;
    checks++; if (d2_fflags !== 5'h11) begin errors++; $display("FAIL flags_accum got %h exp 11", d2_fflags); end
    in_valid = 1; status_i = 5'h04; tick();
    in_valid = 0; out_ready = 1; clr = 1; tick();
    out_ready = 0; clr = 0; #1;
    checks++; if (d2_fflags !== 5'h04) begin errors++; $display("FAIL flags_clr_pop got %h exp 04", d2_fflags); end
    clr = 1; tick(); clr = 0; #1;
    checks++; if (d2_fflags !== 5'h00) begin errors++; $display("FAIL flags_clr got %h exp 00", d2_fflags); end
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1; status_i = 5'h02;
    for (int i = 0; i < 4; i++) begin result_i = 32'hA0 + 32'(i); tick(); end
    in_valid = 0; out_ready = 1; tick(); out_ready = 0; #1;
    checks++; if (d4_count !== 3'd3 || d4_fflags !== 5'h02) begin errors++; $display("FAIL flush_setup got c=%0d f=%h exp c=3 f=02", d4_count, d4_fflags); end
    in_valid = 1; flush = 1; out_ready = 1; result_i = 32'hDEAD; status_i = 5'h08; #1;
    checks++; if (d4_out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b exp 0", d4_out_valid); end
    checks++; if (d4_in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b exp 1", d4_in_ready); end
    tick(); flush = 0; in_valid = 0; out_ready = 0; #1;
    checks++; if (d4_count !== 3'd0 || d4_busy !== 1'b0) begin errors++; $display("FAIL flush_count got c=%0d b=%b exp 0/0", d4_count, d4_busy); end
    checks++; if (d4_fflags !== 5'h02) begin errors++; $display("FAIL flush_fflags got %h exp 02", d4_fflags); end
    in_valid = 1; result_i = 32'hAB; tick(); in_valid = 0; #1;
    checks++; if (d4_result !== 32'hAB || d4_count !== 3'd1) begin errors++; $display("FAIL post_flush got r=%h c=%0d exp ab/1", d4_result, d4_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_valid = 1; status_i = 5'h08; tick(); tick();
    out_ready = 1; in_valid = 0; tick(); out_ready = 0; #1;
    checks++; if (d4_fflags !== 5'h08) begin errors++; $display("FAIL mid_setup got %h exp 08", d4_fflags); end
    rst = 1; in_valid = 1; out_ready = 1; tick(); rst = 0; in_valid = 0; out_ready = 0; #1;
    checks++; if (d4_count !== 3'd0 || d4_fflags !== 5'h00) begin errors++; $display("FAIL mid_reset got c=%0d f=%h exp 0/00", d4_count, d4_fflags); end
  endtask

  task automatic test_bypass();
    do_reset();
    result_i = 32'h55; status_i = 5'h01; in_valid = 1; out_ready = 1; #1;
`ifdef FPNEW_RESULT_BUFFER_BYPASS_EN
    checks++; if (d2_out_valid !== 1'b1 || d2_result !== 32'h55) begin errors++; $display("FAIL bypass_same_cycle got v=%b r=%h exp 1/55", d2_out_valid, d2_result); end
    tick(); in_valid = 0; out_ready = 0; #1;
    checks++; if (d2_count !== 2'd0 || d2_fflags !== 5'h01) begin errors++; $display("FAIL bypass_after got c=%0d f=%h exp 0/01", d2_count, d2_fflags); end
`else
    checks++; if (d2_out_valid !== 1'b0) begin errors++; $display("FAIL latency_same_cycle got %b exp 0", d2_out_valid); end
    tick(); in_valid = 0; out_ready = 0; #1;
    checks++; if (d2_count !== 2'd1 || d2_result !== 32'h55) begin errors++; $display("FAIL latency_stored got c=%0d r=%h exp 1/55", d2_count, d2_result); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_fflags();
    test_flush();
    test_reset_mid();
    test_bypass();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
